money_render_ctrl: RTL and testbench
====================================

MONEY_RENDER_CTRL -- requirements
Module: money_render_ctrl

Interface
REQ-001 Params SHALL be: NUM_PALLETS, default 4, number of money pallets; RESPAWN_FRAMES, default 180, frames an emptied pallet waits before refilling.
REQ-002 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 ResetN  input  1  asynchronous, active-low reset.
REQ-004 FrameTick  input  1  one-cycle pulse per video frame, at vsync.
REQ-005 DrawX, DrawY  input  10 each  current VGA pixel coordinate.
REQ-006 PalletX, PalletY  input  NUM_PALLETS x 10 each  top-left corner of each pallet.
REQ-007 Grab  input  NUM_PALLETS  one-cycle grab request per pallet from the player logic.
REQ-008 GrabAck  output  NUM_PALLETS  one-cycle pulse when a grab is accepted.
REQ-009 PalletTile  output  NUM_PALLETS x 2  live fill state per pallet: 2 = full, 1 = half, 0 = empty.
REQ-010 Tile  output  2; PixelX, PixelY  output  5 each; these SHALL drive the money sprite ROM address.
REQ-011 RomData  input  6  combinational ROM colour for the current Tile/PixelX/PixelY.
REQ-012 Color  output  6  pixel colour; ColorValid  output  1  high when Color is opaque money.

Function
REQ-013 Each pallet SHALL have a state machine with states FULL, HALF and EMPTY, output on PalletTile as 2, 1 and 0.
REQ-014 Transitions on Grab:
- FULL -> HALF, with a GrabAck pulse on the next cycle.
- HALF -> EMPTY, with a GrabAck pulse, and the respawn counter loaded with RESPAWN_FRAMES.
- Grab in EMPTY SHALL be ignored, with no ack.
REQ-015 In EMPTY, the counter SHALL decrement on each FrameTick; a FrameTick seen with the counter at 1 SHALL move the pallet to FULL.
REQ-016 Grab and FrameTick in the same cycle: the grab transition SHALL apply, and a counter load SHALL win over a decrement.
REQ-017 Render snapshot: on FrameTick, all pallet states SHALL be copied into a render register. Rendering SHALL use only this copy, so no tile changes mid-frame.
REQ-018 Stage 1, one cycle after DrawX/DrawY:
- dx = DrawX - PalletX[i] and dy = DrawY - PalletY[i], 10-bit unsigned with wrap.
- Pallet i hits when dx < 18 and dy < 18.
- The lowest-index hitting pallet SHALL win.
- Tile, PixelX = dx[4:0] and PixelY = dy[4:0] SHALL be registered for the winner, together with a Hit flag.
REQ-019 With no hit in stage 1, Tile, PixelX and PixelY SHALL hold 0.
REQ-020 Stage 2: Color SHALL register RomData, and ColorValid SHALL register Hit && RomData != TRANSPARENT. Total latency is 2 cycles from DrawX/DrawY to Color.
REQ-021 A pallet with its left or top edge near 0 or 639/479 SHALL clip naturally. A wrapped dx or dy of 1006 or more SHALL never register as a hit.
REQ-022 Pallet states SHALL be independent; simultaneous grabs on several pallets SHALL all be processed in the same cycle.

Reset
REQ-023 While ResetN is low:
- all pallets SHALL be FULL, counters 0, snapshot all FULL;
- GrabAck SHALL be 0;
- Tile, PixelX, PixelY and Hit SHALL be 0;
- Color SHALL be 0 and ColorValid 0.
REQ-024 Reset asserted mid-respawn SHALL abort the countdown, and the pallet SHALL return FULL. Reset release SHALL require no FrameTick before grabs are accepted.

Structure
REQ-025 Package money_pkg SHALL hold:
- SPRITE_SIZE = 18;
- TRANSPARENT = 6'd0;
- default NUM_PALLETS and RESPAWN_FRAMES;
- enum pallet_state_t {EMPTY = 0, HALF = 1, FULL = 2}.
REQ-026 Sub-module money_pallet_fsm SHALL implement one pallet: the state machine, respawn counter and ack. It SHALL be instantiated NUM_PALLETS times via generate.
REQ-027 The sprite ROM SHALL stay outside this block and be connected at the parent level.

Verification
REQ-028 Grab pallet 0 twice, 5 cycles apart -> GrabAck[0] pulses twice; PalletTile[0] goes 2 -> 1 -> 0; a third grab gives no ack.
REQ-029 Empty pallet 1 with RESPAWN_FRAMES = 3, then pulse FrameTick three times -> PalletTile[1] = 2 exactly after the third tick.
REQ-030 PalletX[0] = 100, PalletY[0] = 50, DrawX = 105, DrawY = 60 -> two cycles later Tile = 2, PixelX = 5, PixelY = 10, and ColorValid = 1 if RomData is nonzero.
REQ-031 Pallets 0 and 2 overlap at (200, 200) with pallet 0 HALF after the snapshot -> Tile = 1 (pallet 0 wins); DrawX = 99 with PalletX = 100 -> ColorValid = 0.
REQ-032 Grab pallet 0 mid-frame -> PalletTile changes immediately, but the rendered Tile changes only after the next FrameTick.
REQ-033 Assert ResetN low during a respawn countdown -> all outputs 0 and all PalletTile = 2 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/money_pkg.sv
// Shared constants and types for the money pallet renderer: sprite geometry,
// the transparent colour key and the per-pallet fill state encoding.
package money_pkg;

  localparam int SPRITE_SIZE            = 18;
  localparam logic [5:0] TRANSPARENT    = 6'd0;
  localparam int DEF_NUM_PALLETS        = 4;
  localparam int DEF_RESPAWN_FRAMES     = 180;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pallet_state_t;

  // True when a wrapped 10-bit offset lies inside the sprite box. Any wrapped
  // value (1006 and above) is far past SPRITE_SIZE and can never hit.
  function automatic logic in_sprite(input logic [9:0] d);
    return d < 10'(SPRITE_SIZE);
  endfunction

endpackage

// File: rtl/money_pallet_fsm.sv
// One money pallet: FULL -> HALF -> EMPTY on grabs, then a frame-counted
// respawn back to FULL. The live state is exposed on state_o.
module money_pallet_fsm
  import money_pkg::*;
#(
  parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       grab,
  output logic       grab_ack,
  output logic [1:0] state_o
);

  localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);
  localparam logic [CNT_W-1:0] RESPAWN_LD = CNT_W'(RESPAWN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  pallet_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;

  // Handshake: grab is a single-cycle request with no back-pressure. An
  // accepted grab (FULL or HALF) yields a one-cycle grab_ack on the following
  // cycle; a grab in EMPTY is dropped silently and never acknowledged.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    case (state_q)
      FULL: begin
        if (grab) begin
          state_d = HALF;
          ack_d   = 1'b1;
        end
      end
      HALF: begin
        // The load here takes priority over any same-cycle frame tick.
        if (grab) begin
          state_d = EMPTY;
          ack_d   = 1'b1;
          cnt_d   = RESPAWN_LD;
        end
      end
      EMPTY: begin
        if (frame_tick) begin
          if (cnt_q <= CNT_ONE) begin
            state_d = FULL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: begin
        state_d = FULL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FULL;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  assign grab_ack = ack_q;
  assign state_o  = state_q;

endmodule

// File: rtl/money_render_ctrl.sv
// Money pallet controller: per-pallet grab/respawn FSMs plus a two-stage
// sprite renderer that reads a once-per-frame snapshot of the pallet states.
module money_render_ctrl
  import money_pkg::*;
#(
  parameter int NUM_PALLETS    = DEF_NUM_PALLETS,
  parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES
) (
  input  logic                      Clk,
  input  logic                      ResetN,
  input  logic                      FrameTick,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic [NUM_PALLETS*10-1:0] PalletX,
  input  logic [NUM_PALLETS*10-1:0] PalletY,
  input  logic [NUM_PALLETS-1:0]    Grab,
  output logic [NUM_PALLETS-1:0]    GrabAck,
  output logic [NUM_PALLETS*2-1:0]  PalletTile,
  output logic [1:0]                Tile,
  output logic [4:0]                PixelX,
  output logic [4:0]                PixelY,
  input  logic [5:0]                RomData,
  output logic [5:0]                Color,
  output logic                      ColorValid
);

  logic [NUM_PALLETS*2-1:0] live_tile;

  for (genvar g = 0; g < NUM_PALLETS; g++) begin : g_pallet
    money_pallet_fsm #(
      .RESPAWN_FRAMES(RESPAWN_FRAMES)
    ) u_fsm (
      .clk       (Clk),
      .rst_n     (ResetN),
      .frame_tick(FrameTick),
      .grab      (Grab[g]),
      .grab_ack  (GrabAck[g]),
      .state_o   (live_tile[g*2 +: 2])
    );
  end

  assign PalletTile = live_tile;

  // Render snapshot: frozen at vsync so a tile never changes mid-frame.
  localparam logic [NUM_PALLETS*2-1:0] SNAP_FULL = {NUM_PALLETS{FULL}};

  logic [NUM_PALLETS*2-1:0] snap_q, snap_d;

  always_comb begin
    snap_d = snap_q;
    if (FrameTick) snap_d = live_tile;
  end

  // Stage 1: hit test against every pallet; lower indices are evaluated last
  // so the lowest-index hitting pallet ends up as the winner.
  logic       hit_q, hit_d;
  logic [1:0] tile_q, tile_d;
  logic [4:0] px_q, px_d;
  logic [4:0] py_q, py_d;
  logic [9:0] dx, dy;

  always_comb begin
    hit_d  = 1'b0;
    tile_d = '0;
    px_d   = '0;
    py_d   = '0;
    dx     = '0;
    dy     = '0;
    for (int i = NUM_PALLETS - 1; i >= 0; i--) begin
      dx = DrawX - PalletX[i*10 +: 10];
      dy = DrawY - PalletY[i*10 +: 10];
      if (in_sprite(dx) && in_sprite(dy)) begin
        hit_d  = 1'b1;
        tile_d = snap_q[i*2 +: 2];
        px_d   = dx[4:0];
        py_d   = dy[4:0];
      end
    end
  end

  // Stage 2: register the external ROM colour against the stage-1 address.
  logic [5:0] color_q, color_d;
  logic       valid_q, valid_d;

  always_comb begin
    color_d = RomData;
    valid_d = hit_q && (RomData != TRANSPARENT);
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      snap_q  <= SNAP_FULL;
      hit_q   <= 1'b0;
      tile_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      color_q <= '0;
      valid_q <= 1'b0;
    end else begin
      snap_q  <= snap_d;
      hit_q   <= hit_d;
      tile_q  <= tile_d;
      px_q    <= px_d;
      py_q    <= py_d;
      color_q <= color_d;
      valid_q <= valid_d;
    end
  end

  assign Tile       = tile_q;
  assign PixelX     = px_q;
  assign PixelY     = py_q;
  assign Color      = color_q;
  assign ColorValid = valid_q;

endmodule

// File: tb/tb_money_render_ctrl.sv
// Directed bench for money_render_ctrl with a tiny combinational sprite ROM
// model: colour 0 on sprite column 0, otherwise {Tile, PixelY[3:0]}.
module tb_money_render_ctrl;

  localparam int NP = 4;

  logic           Clk = 1'b0;
  logic           ResetN;
  logic           FrameTick;
  logic [9:0]     DrawX, DrawY;
  logic [NP*10-1:0] PalletX, PalletY;
  logic [NP-1:0]  Grab;
  logic [NP-1:0]  GrabAck;
  logic [NP*2-1:0] PalletTile;
  logic [1:0]     Tile;
  logic [4:0]     PixelX, PixelY;
  logic [5:0]     RomData;
  logic [5:0]     Color;
  logic           ColorValid;

  int n_vec = 0;
  int n_err = 0;

  money_render_ctrl #(
    .NUM_PALLETS   (NP),
    .RESPAWN_FRAMES(3)
  ) dut (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .FrameTick (FrameTick),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .PalletX   (PalletX),
    .PalletY   (PalletY),
    .Grab      (Grab),
    .GrabAck   (GrabAck),
    .PalletTile(PalletTile),
    .Tile      (Tile),
    .PixelX    (PixelX),
    .PixelY    (PixelY),
    .RomData   (RomData),
    .Color     (Color),
    .ColorValid(ColorValid)
  );

  // Clock / reset block
  always #5 Clk = ~Clk;

  assign RomData = (PixelX == 5'd0) ? 6'd0 : {Tile, PixelY[3:0]};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic grab_pulse(input logic [NP-1:0] g);
    Grab = g;
    step();
    Grab = '0;
  endtask

  task automatic frame_pulse();
    FrameTick = 1'b1;
    step();
    FrameTick = 1'b0;
  endtask

  task automatic set_pallet(input int i, input logic [9:0] x, input logic [9:0] y);
    PalletX[i*10 +: 10] = x;
    PalletY[i*10 +: 10] = y;
  endtask

  task automatic do_reset();
    Grab      = '0;
    FrameTick = 1'b0;
    ResetN    = 1'b0;
    step(2);
    ResetN = 1'b1;
  endtask

  task automatic default_layout();
    set_pallet(0, 10'd100, 10'd50);
    set_pallet(1, 10'd300, 10'd300);
    set_pallet(2, 10'd400, 10'd300);
    set_pallet(3, 10'd500, 10'd300);
  endtask

  initial begin
    ResetN    = 1'b1;
    FrameTick = 1'b0;
    Grab      = '0;
    DrawX     = '0;
    DrawY     = '0;
    PalletX   = '0;
    PalletY   = '0;
    default_layout();

    // Reset state, observed before any clock edge
    #2 ResetN = 1'b0;
    #2;
    check_eq("rst_pallet_tile", PalletTile, 8'hAA);
    check_eq("rst_grab_ack", GrabAck, 4'h0);
    check_eq("rst_tile", {Tile, PixelX, PixelY}, 12'd0);
    check_eq("rst_color", {ColorValid, Color}, 7'd0);
    step(2);
    ResetN = 1'b1;

    // Grab pallet 0 twice, five cycles apart, then once more while empty
    grab_pulse(4'b0001);
    check_eq("g1_ack", GrabAck, 4'b0001);
    check_eq("g1_tile", PalletTile[1:0], 2'd1);
    step();
    check_eq("g1_ack_drop", GrabAck, 4'b0000);
    step(3);
    grab_pulse(4'b0001);
    check_eq("g2_ack", GrabAck, 4'b0001);
    check_eq("g2_tile", PalletTile[1:0], 2'd0);
    grab_pulse(4'b0001);
    check_eq("g3_no_ack", GrabAck, 4'b0000);
    check_eq("g3_tile", PalletTile[1:0], 2'd0);

    // Simultaneous grabs on every pallet
    do_reset();
    grab_pulse(4'b1111);
    check_eq("all_ack", GrabAck, 4'b1111);
    check_eq("all_tile", PalletTile, 8'h55);

    // Respawn of pallet 1 after three frame ticks
    grab_pulse(4'b0010);
    check_eq("p1_empty", PalletTile[3:2], 2'd0);
    frame_pulse();
    check_eq("p1_tick1", PalletTile[3:2], 2'd0);
    frame_pulse();
    check_eq("p1_tick2", PalletTile[3:2], 2'd0);
    frame_pulse();
    check_eq("p1_tick3", PalletTile[3:2], 2'd2);

    // Grab and FrameTick together on HALF pallet 2: load beats decrement
    Grab      = 4'b0100;
    FrameTick = 1'b1;
    step();
    Grab      = '0;
    FrameTick = 1'b0;
    check_eq("p2_same_ack", GrabAck, 4'b0100);
    check_eq("p2_same_tile", PalletTile[5:4], 2'd0);
    frame_pulse();
    frame_pulse();
    check_eq("p2_tick2", PalletTile[5:4], 2'd0);
    frame_pulse();
    check_eq("p2_tick3", PalletTile[5:4], 2'd2);

    // Render pipeline: hit inside pallet 0 at (100,50)
    do_reset();
    DrawX = 10'd105;
    DrawY = 10'd60;
    step();
    check_eq("r1_addr", {Tile, PixelX, PixelY}, {2'd2, 5'd5, 5'd10});
    step();
    check_eq("r1_color", {ColorValid, Color}, {1'b1, 6'd42});

    // Corner pixel reads a transparent ROM entry
    DrawX = 10'd100;
    DrawY = 10'd50;
    step();
    check_eq("r2_addr", {Tile, PixelX, PixelY}, {2'd2, 5'd0, 5'd0});
    step();
    check_eq("r2_color", {ColorValid, Color}, {1'b0, 6'd0});

    // Last pixel inside the box, then one past it
    DrawX = 10'd117;
    DrawY = 10'd67;
    step(2);
    check_eq("r3_edge_in", {ColorValid, Color}, {1'b1, 6'd33});
    DrawX = 10'd118;
    step();
    check_eq("r4_edge_out_addr", {Tile, PixelX, PixelY}, 12'd0);
    step();
    check_eq("r4_edge_out_valid", ColorValid, 1'b0);

    // One pixel left of the pallet wraps dx to 1023
    DrawX = 10'd99;
    DrawY = 10'd60;
    step(2);
    check_eq("r5_wrap_addr", {Tile, PixelX, PixelY}, 12'd0);
    check_eq("r5_wrap_valid", ColorValid, 1'b0);

    // Overlapping pallets 0 and 2; grab pallet 0 mid-frame
    do_reset();
    set_pallet(0, 10'd200, 10'd200);
    set_pallet(2, 10'd200, 10'd200);
    DrawX = 10'd205;
    DrawY = 10'd203;
    grab_pulse(4'b0001);
    check_eq("ov_live_tile", PalletTile[1:0], 2'd1);
    step();
    check_eq("ov_pre_frame_tile", Tile, 2'd2);
    frame_pulse();
    check_eq("ov_tick_edge_tile", Tile, 2'd2);
    step();
    check_eq("ov_post_frame_addr", {Tile, PixelX, PixelY}, {2'd1, 5'd5, 5'd3});
    step();
    check_eq("ov_color", {ColorValid, Color}, {1'b1, 6'd19});

    // Asynchronous reset in the middle of a respawn countdown
    do_reset();
    default_layout();
    DrawX = 10'd105;
    DrawY = 10'd60;
    grab_pulse(4'b0010);
    grab_pulse(4'b0010);
    check_eq("ar_pre_ack", GrabAck, 4'b0010);
    frame_pulse();
    check_eq("ar_pre_tile", PalletTile[3:2], 2'd0);
    check_eq("ar_pre_color", {ColorValid, Color}, {1'b1, 6'd42});
    #3 ResetN = 1'b0;
    #1;
    check_eq("ar_pallet_tile", PalletTile, 8'hAA);
    check_eq("ar_outputs", {GrabAck, Tile, PixelX, PixelY, ColorValid, Color}, 23'd0);
    step();
    ResetN = 1'b1;
    grab_pulse(4'b0010);
    check_eq("ar_post_ack", GrabAck, 4'b0010);
    check_eq("ar_post_tile", PalletTile[3:2], 2'd1);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
